// File: rtl/pe_out_act_tx.sv
// PE output activation transmitter: buffers result activations and sends them
// as DATA flits over a valid/ready link, closing each layer with an EOL flit.
module pe_out_act_tx #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8,
   parameter int DEST_W = 4,
   parameter int DEPTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              push_out,
   input  logic [DATA_W-1:0]                 out_data,
   input  logic [IDX_W-1:0]                  out_idx,
   output logic                              out_full,
   output logic                              out_full_next,
   output logic [$clog2(DEPTH):0]            queue_count,
   input  logic                              flush_req,
   output logic                              flush_done,
   output logic                              overflow_err,
   output logic                              tx_valid,
   output logic [2+DEST_W+IDX_W+DATA_W-1:0]  tx_flit,
   input  logic                              tx_ready
);

   localparam int AW     = $clog2(DEPTH);
   localparam int PTR_W  = AW + 1;
   localparam int ENT_W  = IDX_W + DATA_W;
   localparam int FLIT_W = 2 + DEST_W + IDX_W + DATA_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_EOL
   } state_t;

   state_t             state;
   logic [ENT_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [PTR_W-1:0]   count_next;
   logic [ENT_W-1:0]   head;
   logic [IDX_W-1:0]   head_idx;
   logic [DATA_W-1:0]  head_data;
   logic               empty;
   logic               push_acc;
   logic               pop;
   logic               eol_load;

   // Pointers carry an extra wrap bit, so their difference is the fill level.
   assign queue_count   = wptr - rptr;
   assign empty         = (wptr == rptr);
   assign out_full      = (queue_count == PTR_W'(DEPTH));
   assign push_acc      = push_out & ~out_full;
   assign pop           = ~empty & (~tx_valid | tx_ready);
   assign eol_load      = (state == S_DRAIN) & empty & (~tx_valid | tx_ready);
   assign count_next    = queue_count + PTR_W'(push_acc) - PTR_W'(pop);
   assign out_full_next = (count_next == PTR_W'(DEPTH));

   assign head      = mem[rptr[AW-1:0]];
   assign head_idx  = head[ENT_W-1:DATA_W];
   assign head_data = head[DATA_W-1:0];

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wptr[AW-1:0]] <= {out_idx, out_data};
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         wptr         <= '0;
         rptr         <= '0;
         tx_valid     <= 1'b0;
         tx_flit      <= '0;
         flush_done   <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         if (push_acc) wptr <= wptr + 1'b1;
         if (push_out && out_full) overflow_err <= 1'b1;
         if (pop) rptr <= rptr + 1'b1;

         // Buffered data always wins the output register; EOL only goes out
         // once nothing is left ahead of it.
         if (pop) begin
            tx_valid <= 1'b1;
            tx_flit  <= {2'b01, head_idx[DEST_W-1:0], head_idx, head_data};
         end else if (eol_load) begin
            tx_valid <= 1'b1;
            tx_flit  <= {2'b10, {(FLIT_W-2){1'b0}}};
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end

         case (state)
            S_IDLE:  if (flush_req) state <= S_DRAIN;
            S_DRAIN: if (eol_load) state <= S_EOL;
            S_EOL: begin
               if (tx_ready) begin
                  flush_done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_out_act_tx.sv
// Directed bench for pe_out_act_tx: latency, backpressure, overflow, flush/EOL
// sequencing and asynchronous reset, with flits captured by a link monitor.
module tb_pe_out_act_tx;

   localparam int FLIT_W = 30;
   localparam logic [FLIT_W-1:0] EOL_FLIT = 30'h2000_0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              push_out;
   logic [15:0]       out_data;
   logic [7:0]        out_idx;
   logic              out_full;
   logic              out_full_next;
   logic [3:0]        queue_count;
   logic              flush_req;
   logic              flush_done;
   logic              overflow_err;
   logic              tx_valid;
   logic [FLIT_W-1:0] tx_flit;
   logic              tx_ready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [FLIT_W-1:0] rx_q[$];
   int flush_cnt = 0;

   pe_out_act_tx #(.DATA_W(16), .IDX_W(8), .DEST_W(4), .DEPTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_out      (push_out),
      .out_data      (out_data),
      .out_idx       (out_idx),
      .out_full      (out_full),
      .out_full_next (out_full_next),
      .queue_count   (queue_count),
      .flush_req     (flush_req),
      .flush_done    (flush_done),
      .overflow_err  (overflow_err),
      .tx_valid      (tx_valid),
      .tx_flit       (tx_flit),
      .tx_ready      (tx_ready)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge, so mid-cycle values are stable.
   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) rx_q.push_back(tx_flit);
      if (rst_n && flush_done) flush_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FLIT_W-1:0] data_flit(input logic [7:0] idx, input logic [15:0] d);
      return {2'b01, idx[3:0], idx, d};
   endfunction

   task automatic push(input logic [7:0] idx, input logic [15:0] d);
      push_out = 1'b1;
      out_idx  = idx;
      out_data = d;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " tx_valid"}, 64'(tx_valid), 64'd0);
      check({tag, " tx_flit"}, 64'(tx_flit), 64'd0);
      check({tag, " out_full"}, 64'(out_full), 64'd0);
      check({tag, " out_full_next"}, 64'(out_full_next), 64'd0);
      check({tag, " queue_count"}, 64'(queue_count), 64'd0);
      check({tag, " flush_done"}, 64'(flush_done), 64'd0);
      check({tag, " overflow_err"}, 64'(overflow_err), 64'd0);
   endtask

   initial begin
      int base;
      int f0;
      logic held;
      logic [FLIT_W-1:0] held_flit;
      logic eol_seen;

      rst_n = 1'b0; push_out = 1'b0; out_data = '0; out_idx = '0;
      flush_req = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // 1: single push, two-edge latency, expected flit 0x1323_00AA
      tx_ready = 1'b1;
      push(8'h23, 16'h00AA);
      step();
      push_out = 1'b0;
      check("t1 count after push", 64'(queue_count), 64'd1);
      check("t1 not yet valid", 64'(tx_valid), 64'd0);
      step();
      check("t1 valid", 64'(tx_valid), 64'd1);
      check("t1 flit", 64'(tx_flit), 64'(30'h1323_00AA));
      check("t1 count back to 0", 64'(queue_count), 64'd0);
      step();
      check("t1 valid clears", 64'(tx_valid), 64'd0);

      // 2: fill under backpressure; first entry moves into the output
      // register, so the buffer reaches 8 entries on the 9th push.
      base = rx_q.size();
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         push(8'h40 + 8'(i), 16'h1000 + 16'(i));
         if (i == 8) check("t2 full_next", 64'(out_full_next), 64'd1);
         step();
         if (i == 7) begin
            check("t2 count after 8", 64'(queue_count), 64'd7);
            check("t2 not full after 8", 64'(out_full), 64'd0);
         end
      end
      check("t2 full", 64'(out_full), 64'd1);
      check("t2 count full", 64'(queue_count), 64'd8);
      check("t2 no overflow yet", 64'(overflow_err), 64'd0);
      push(8'hEE, 16'hDEAD);
      step();
      push_out = 1'b0;
      check("t2 overflow", 64'(overflow_err), 64'd1);
      check("t2 count held", 64'(queue_count), 64'd8);
      tx_ready = 1'b1;
      repeat (15) step();
      check("t2 flit count", 64'(rx_q.size() - base), 64'd9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < rx_q.size())
            check($sformatf("t2 flit %0d", i), 64'(rx_q[base+i]),
                  64'(data_flit(8'h40 + 8'(i), 16'h1000 + 16'(i))));
      end
      check("t2 overflow sticky", 64'(overflow_err), 64'd1);

      // 3: alternating ready while pushing
      base = rx_q.size();
      for (int c = 0; c < 20; c++) begin
         tx_ready = (c % 2 == 0);
         if (c < 5) push(8'h60 + 8'(c), 16'h2000 + 16'(c));
         else push_out = 1'b0;
         held = tx_valid & ~tx_ready;
         held_flit = tx_flit;
         step();
         if (held) begin
            check("t3 held valid", 64'(tx_valid), 64'd1);
            check("t3 held flit", 64'(tx_flit), 64'(held_flit));
         end
      end
      tx_ready = 1'b1;
      repeat (3) step();
      check("t3 flit count", 64'(rx_q.size() - base), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < rx_q.size())
            check($sformatf("t3 flit %0d", i), 64'(rx_q[base+i]),
                  64'(data_flit(8'h60 + 8'(i), 16'h2000 + 16'(i))));
      end

      // 4: three pushes then flush -> 3 DATA, EOL, one flush_done
      base = rx_q.size();
      f0 = flush_cnt;
      eol_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(8'h81 + 8'(i), 16'h3000 + 16'(i));
         step();
      end
      push_out = 1'b0;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int c = 0; c < 20 && !eol_seen; c++) begin
         if (tx_valid && tx_ready && tx_flit == EOL_FLIT) begin
            eol_seen = 1'b1;
            step();
            check("t4 flush_done pulse", 64'(flush_done), 64'd1);
            step();
            check("t4 flush_done drops", 64'(flush_done), 64'd0);
         end else begin
            step();
         end
      end
      check("t4 eol seen", 64'(eol_seen), 64'd1);
      repeat (3) step();
      check("t4 flit count", 64'(rx_q.size() - base), 64'd4);
      for (int i = 0; i < 3; i++) begin
         if (base + i < rx_q.size())
            check($sformatf("t4 flit %0d", i), 64'(rx_q[base+i]),
                  64'(data_flit(8'h81 + 8'(i), 16'h3000 + 16'(i))));
      end
      if (base + 3 < rx_q.size())
         check("t4 eol flit", 64'(rx_q[base+3]), 64'(EOL_FLIT));
      check("t4 one flush_done", 64'(flush_cnt - f0), 64'd1);

      // 5: flush on empty buffer; second flush while in EOL is ignored
      base = rx_q.size();
      f0 = flush_cnt;
      tx_ready = 1'b0;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      check("t5 draining", 64'(tx_valid), 64'd0);
      step();
      check("t5 eol valid", 64'(tx_valid), 64'd1);
      check("t5 eol flit", 64'(tx_flit), 64'(EOL_FLIT));
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      check("t5 eol held", 64'(tx_flit), 64'(EOL_FLIT));
      tx_ready = 1'b1;
      repeat (6) step();
      check("t5 one flit", 64'(rx_q.size() - base), 64'd1);
      if (base < rx_q.size()) check("t5 flit is eol", 64'(rx_q[base]), 64'(EOL_FLIT));
      check("t5 one flush_done", 64'(flush_cnt - f0), 64'd1);
      check("t5 idle after", 64'(tx_valid), 64'd0);

      // 6: async reset with a valid flit and four buffered entries
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(8'hA0 + 8'(i), 16'h4000 + 16'(i));
         step();
      end
      push_out = 1'b0;
      check("t6 valid before reset", 64'(tx_valid), 64'd1);
      check("t6 count before reset", 64'(queue_count), 64'd4);
      rst_n = 1'b0;
      #1;
      check_reset_values("t6 async");
      #2;
      rst_n = 1'b1;
      base = rx_q.size();
      tx_ready = 1'b1;
      repeat (5) step();
      check("t6 no flits after reset", 64'(rx_q.size() - base), 64'd0);
      check("t6 still idle", 64'(tx_valid), 64'd0);
      push(8'h5A, 16'hBEEF);
      step();
      push_out = 1'b0;
      step();
      check("t6 new push valid", 64'(tx_valid), 64'd1);
      check("t6 new push flit", 64'(tx_flit), 64'(data_flit(8'h5A, 16'hBEEF)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
